// File: rtl/pipeline_debug_ctrl.sv
// Host debug controller: halts the pipeline, runs or single-steps it, then streams the register bank out.
// Optional DEBUG_CYCLE_COUNT_EN appends a 32-bit count of unstalled cycles to every dump.
module pipeline_debug_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd,
  output logic        cmd_ready,
  input  logic        prog_end,
  output logic        stall,
  output logic [4:0]  addrAsync,
  input  logic [31:0] outputAsync,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, DUMP} ctrlState_e;

  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam logic [7:0] LAST_BYTE = 8'd131;
`else
  localparam logic [7:0] LAST_BYTE = 8'd127;
`endif

  ctrlState_e state;
  logic [7:0] byteCnt;   // stream position of the byte currently on tx_data

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cycleCnt;
`endif

  function automatic logic [7:0] pickByte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    pickByte = word[31:24];
      2'd1:    pickByte = word[23:16];
      2'd2:    pickByte = word[15:8];
      default: pickByte = word[7:0];
    endcase
  endfunction

  logic [7:0] nextPos;
  logic [5:0] fetchReg;
  logic [7:0] nextByte;
  logic [4:0] nextAddr;
  logic       startDump;

  // tx_data is registered, so the bank address runs one byte ahead of the
  // byte on the link: once the last byte of a register is loaded, addrAsync
  // already points at the next register so its first byte is ready on transfer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    nextPos   = byteCnt + 8'd1;
    fetchReg  = 6'((byteCnt + 8'd2) >> 2);
    nextByte  = pickByte(outputAsync, nextPos[1:0]);
`ifdef DEBUG_CYCLE_COUNT_EN
    if (nextPos[7]) nextByte = pickByte(cycleCnt, nextPos[1:0]);
`endif
    nextAddr  = fetchReg[5] ? 5'd0 : fetchReg[4:0];
    startDump = (state == STEP) ||
                (state == RUN  && prog_end) ||
                (state == IDLE && cmd_valid && cmd_ready && cmd == CMD_DUMP);
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      stall     <= 1'b1;
      cmd_ready <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      addrAsync <= 5'd0;
      byteCnt   <= 8'd0;
    end else if (startDump) begin
      // addrAsync is always 0 outside DUMP, so outputAsync already holds reg 0.
      state     <= DUMP;
      stall     <= 1'b1;
      cmd_ready <= 1'b0;
      tx_valid  <= 1'b1;
      tx_data   <= outputAsync[31:24];
      addrAsync <= 5'd0;
      byteCnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            case (cmd)
              CMD_RUN: begin
                state     <= RUN;
                stall     <= 1'b0;
                cmd_ready <= 1'b0;
              end
              CMD_STEP: begin
                state     <= STEP;
                stall     <= 1'b0;
                cmd_ready <= 1'b0;
              end
              default: ;  // unknown bytes are consumed and dropped
            endcase
          end
        end
        DUMP: begin
          if (tx_ready) begin
            if (byteCnt == LAST_BYTE) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              tx_valid  <= 1'b0;
              tx_data   <= 8'd0;
              addrAsync <= 5'd0;
              byteCnt   <= 8'd0;
            end else begin
              byteCnt   <= nextPos;
              tx_data   <= nextByte;
              addrAsync <= nextAddr;
            end
          end
        end
        default: ;  // RUN without prog_end keeps running; STEP is handled by startDump
      endcase
    end
  end

`ifdef DEBUG_CYCLE_COUNT_EN
  // Counts cycles the pipeline actually advanced; wraps naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset)       cycleCnt <= 32'd0;
    else if (!stall) cycleCnt <= cycleCnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Self-checking bench for pipeline_debug_ctrl: table-driven IDLE vectors, directed
// run/step/dump sequences and randomized dumps checked against a byte-stream model.
module tb_pipeline_debug_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic        cmd_ready;
  logic        prog_end;
  logic        stall;
  logic [4:0]  addrAsync;
  logic [31:0] outputAsync;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [31:0] regBank [32];
  assign outputAsync = regBank[addrAsync];

  always #5 clock = ~clock;

  pipeline_debug_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .prog_end    (prog_end),
    .stall       (stall),
    .addrAsync   (addrAsync),
    .outputAsync (outputAsync),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int DUMP_LEN = 132;
`else
  localparam int DUMP_LEN = 128;
`endif

  typedef struct {
    logic       cmdValid;
    logic [7:0] cmdByte;
    logic       expStall;
    logic       expCmdReady;
    logic       expTxValid;
  } idleVec_t;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] expCycles;
  logic [7:0]  gotBytes[$];
  logic [7:0]  expBytes[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_stall"},     32'(stall),     32'd1);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 8'd0;
    prog_end  = 1'b0;
    tx_ready  = 1'b0;
    tick();
    checkIdle("reset");
    check("reset_tx_data",   32'(tx_data),   32'd0);
    check("reset_addrAsync", 32'(addrAsync), 32'd0);
    tick();
    reset     = 1'b0;
    expCycles = 32'd0;
    tick();
    checkIdle("post_reset");
  endtask

  task automatic fillBank();
    for (int r = 0; r < 32; r++) regBank[r] = $urandom;
  endtask

  // Reference stream: each register MSB first, optionally followed by the cycle count.
  task automatic buildExpected();
    expBytes.delete();
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++)
        expBytes.push_back(8'((regBank[r] >> (24 - 8 * b)) & 32'hFF));
`ifdef DEBUG_CYCLE_COUNT_EN
    for (int b = 0; b < 4; b++)
      expBytes.push_back(8'((expCycles >> (24 - 8 * b)) & 32'hFF));
`endif
  endtask

  task automatic sendCmd(input logic [7:0] c);
    check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  // readyMode: 0 = always ready, 1 = alternating 1-0-1, 2 = random.
  task automatic runDump(input int readyMode, input int stopAfter, input bit cmdNoise);
    int cyc = 0;
    int gaps = 0;
    int unstable = 0;
    int badCtrl = 0;
    bit holdPrev = 1'b0;
    logic [7:0] prevData = 8'd0;
    logic [4:0] prevAddr = 5'd0;
    logic ready;
    buildExpected();
    gotBytes.delete();
    while (gotBytes.size() < stopAfter && cyc < 3000) begin
      case (readyMode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2 == 0);
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
      tx_ready  = ready;
      cmd_valid = cmdNoise && ($urandom_range(0, 7) == 0);
      cmd       = 8'h53;
      if (holdPrev && (tx_data !== prevData || addrAsync !== prevAddr)) unstable++;
      if (tx_valid !== 1'b1) gaps++;
      if (stall !== 1'b1 || cmd_ready !== 1'b0) badCtrl++;
      if (tx_valid === 1'b1 && ready) gotBytes.push_back(tx_data);
      holdPrev = (tx_valid === 1'b1) && !ready;
      prevData = tx_data;
      prevAddr = addrAsync;
      tick();
      cyc++;
    end
    tx_ready  = 1'b0;
    cmd_valid = 1'b0;
    check("dump_byte_count", 32'(gotBytes.size()), 32'(stopAfter));
    check("dump_valid_gaps", 32'(gaps),     32'd0);
    check("dump_hold_stable", 32'(unstable), 32'd0);
    check("dump_ctrl_outputs", 32'(badCtrl), 32'd0);
    for (int i = 0; i < gotBytes.size(); i++)
      check($sformatf("dump_byte%0d", i), 32'(gotBytes[i]), 32'(expBytes[i]));
    if (stopAfter == DUMP_LEN) begin
      checkIdle("dump_end");
      tick();
      checkIdle("dump_end_settled");
    end
  endtask

  idleVec_t vecs[8];

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 8'd0;
    prog_end  = 1'b0;
    tx_ready  = 1'b0;
    expCycles = 32'd0;
    for (int r = 0; r < 32; r++) regBank[r] = 32'd0;

    doReset();

    // Commands that must leave the controller idle.
    vecs[0] = '{1'b1, 8'h41, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h72, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h52, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'h73, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'h64, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cmd_valid = vecs[i].cmdValid;
      cmd       = vecs[i].cmdByte;
      tick();
      cmd_valid = 1'b0;
      check($sformatf("vec%0d_stall", i),     32'(stall),     32'(vecs[i].expStall));
      check($sformatf("vec%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].expCmdReady));
      check($sformatf("vec%0d_tx_valid", i),  32'(tx_valid),  32'(vecs[i].expTxValid));
      tick();
      check($sformatf("vec%0d_stall_later", i), 32'(stall), 32'(vecs[i].expStall));
    end

    // Single step from reset, with prog_end high during the step.
    doReset();
    fillBank();
    prog_end = 1'b1;
    sendCmd(8'h53);
    check("step_stall_low", 32'(stall),     32'd0);
    check("step_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    prog_end = 1'b0;
    check("step_stall_back", 32'(stall),    32'd1);
    check("step_dump_valid", 32'(tx_valid), 32'd1);
    expCycles = 32'd1;
    runDump(0, DUMP_LEN, 1'b0);

    // Run for 10 cycles, with a stray 'S' pulsed mid-run.
    doReset();
    fillBank();
    sendCmd(8'h52);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("run_stall_low%0d", i), 32'(stall),     32'd0);
      check($sformatf("run_cmd_ready%0d", i), 32'(cmd_ready), 32'd0);
      cmd_valid = (i == 3);
      cmd       = 8'h53;
      prog_end  = (i == 9);
      tick();
    end
    cmd_valid = 1'b0;
    prog_end  = 1'b0;
    check("run_stall_back", 32'(stall),    32'd1);
    check("run_dump_valid", 32'(tx_valid), 32'd1);
    expCycles = 32'd10;
    runDump(0, DUMP_LEN, 1'b0);
`ifdef DEBUG_CYCLE_COUNT_EN
    check("run_trailer0", 32'(gotBytes[128]), 32'h00);
    check("run_trailer1", 32'(gotBytes[129]), 32'h00);
    check("run_trailer2", 32'(gotBytes[130]), 32'h00);
    check("run_trailer3", 32'(gotBytes[131]), 32'h0A);
`endif

    // Dump with a toggling link and a known register 5.
    fillBank();
    regBank[5] = 32'hDEADBEEF;
    sendCmd(8'h44);
    check("dump_entry_stall",     32'(stall),     32'd1);
    check("dump_entry_tx_valid",  32'(tx_valid),  32'd1);
    check("dump_entry_cmd_ready", 32'(cmd_ready), 32'd0);
    check("dump_entry_addr",      32'(addrAsync), 32'd0);
    runDump(1, DUMP_LEN, 1'b0);
    check("reg5_byte20", 32'(gotBytes[20]), 32'hDE);
    check("reg5_byte21", 32'(gotBytes[21]), 32'hAD);
    check("reg5_byte22", 32'(gotBytes[22]), 32'hBE);
    check("reg5_byte23", 32'(gotBytes[23]), 32'hEF);

    // Randomized command mix with random link backpressure.
    for (int iter = 0; iter < 8; iter++) begin
      int kind = $urandom_range(0, 2);
      fillBank();
      if (kind == 0) begin
        prog_end = 1'($urandom_range(0, 1));
        sendCmd(8'h53);
        check("rnd_step_stall_low", 32'(stall), 32'd0);
        tick();
        prog_end = 1'b0;
        expCycles = expCycles + 32'd1;
      end else if (kind == 1) begin
        int runLen = $urandom_range(1, 15);
        sendCmd(8'h52);
        for (int i = 0; i < runLen; i++) begin
          check("rnd_run_stall_low", 32'(stall), 32'd0);
          prog_end = (i == runLen - 1);
          tick();
        end
        prog_end = 1'b0;
        expCycles = expCycles + 32'(runLen);
      end else begin
        sendCmd(8'h44);
      end
      check("rnd_dump_stall", 32'(stall),    32'd1);
      check("rnd_dump_valid", 32'(tx_valid), 32'd1);
      runDump(2, DUMP_LEN, 1'b1);
    end

    // Reset in the middle of a dump; the next dump starts over.
    fillBank();
    sendCmd(8'h44);
    runDump(0, 50, 1'b0);
    reset = 1'b1;
    tick();
    checkIdle("mid_dump_reset");
    check("mid_dump_reset_addr", 32'(addrAsync), 32'd0);
    check("mid_dump_reset_data", 32'(tx_data),   32'd0);
    reset     = 1'b0;
    expCycles = 32'd0;
    tick();
    sendCmd(8'h44);
    runDump(0, DUMP_LEN, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pipeline_debug_ctrl.md
PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

Interface
REQ-001 clock  in  1  sole clock; all state updates on posedge clock.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on posedge clock.
REQ-003 cmd_valid  in  1  host command byte present.
REQ-004 cmd  in  8  command byte: 0x52 'R' run, 0x53 'S' step, 0x44 'D' dump.
REQ-005 cmd_ready  out  1  controller accepts cmd this cycle.
REQ-006 prog_end  in  1  pipeline has retired the halt instruction.
REQ-007 stall  out  1  freezes all pipeline stages when 1.
REQ-008 addrAsync  out  5  register-bank async read address.
REQ-009 outputAsync  in  32  register-bank async read data for addrAsync, same cycle.
REQ-010 tx_data  out  8  byte to host link.
REQ-011 tx_valid  out  1  tx_data valid.
REQ-012 tx_ready  in  1  host link accepts byte; transfer on tx_valid & tx_ready.

Function
REQ-013 FSM states SHALL be IDLE, RUN, STEP, DUMP; all outputs registered.
REQ-014 IDLE: stall=1, cmd_ready=1, tx_valid=0; cmd transfer when cmd_valid & cmd_ready.
REQ-015 IDLE + 'R' -> RUN; + 'S' -> STEP; + 'D' -> DUMP; any other byte consumed and ignored, stay IDLE.
REQ-016 cmd_ready SHALL be 0 in all states except IDLE.
REQ-017 RUN: stall=0 from the cycle after acceptance; prog_end=1 sampled in RUN -> stall=1 next cycle and move to DUMP.
REQ-018 STEP: stall=0 for exactly one clock cycle, then stall=1 and move to DUMP.
REQ-019 STEP with prog_end=1 SHALL still advance exactly one cycle.
REQ-020 DUMP: stall=1; register index reg_idx 0..31, byte index 0..3; addrAsync=reg_idx.
REQ-021 Byte order per register: outputAsync[31:24], [23:16], [15:8], [7:0].
REQ-022 tx_valid=1 throughout DUMP; tx_data SHALL stay stable until tx_ready=1; byte index advances only on transfer.
REQ-023 After byte 3 of a register, reg_idx increments; after reg 31 byte 3 (and trailer, REQ-030) -> IDLE.
REQ-024 Dump length: 128 bytes without trailer; tx_ready held 1 -> one byte per cycle, no gaps.
REQ-025 tx_ready=0 indefinitely SHALL hold state, tx_data and addrAsync unchanged.
REQ-026 reg_idx and byte index SHALL reset to 0 on every DUMP entry.
REQ-027 cmd_valid outside IDLE SHALL be ignored and not buffered.

Reset
REQ-028 reset=1: state=IDLE, stall=1, cmd_ready=1 on next cycle, tx_valid=0, tx_data=0, addrAsync=0, counters 0.
REQ-029 reset during RUN, STEP or DUMP SHALL abort immediately; partial dump is not resumed.

Configuration
REQ-030 Macro DEBUG_CYCLE_COUNT_EN defined: 32-bit cycle_cnt increments each cycle with stall=0, wraps 0xFFFFFFFF->0, cleared only by reset; a dump appends 4 bytes of cycle_cnt MSB first after reg 31 (132 bytes total).
REQ-031 Macro undefined: no counter logic; dump is exactly 128 bytes.

Verification
REQ-032 Reset, then cmd 'S' with tx_ready=1 -> stall=0 exactly 1 cycle, then 128 bytes (132 with macro), first 4 = reg0 value MSB first, cmd_ready=1 after.
REQ-033 cmd 'R', prog_end asserted 10 cycles after acceptance -> stall=0 for 10 cycles, then dump; with macro trailer bytes = 0x00,0x00,0x00,0x0A.
REQ-034 cmd 'D', reg5=0xDEADBEEF, tx_ready toggled 1-0-1 -> bytes 20..23 = 0xDE,0xAD,0xBE,0xEF, no duplicates/drops.
REQ-035 cmd 0x41 in IDLE -> consumed, state IDLE, stall=1, tx_valid=0.
REQ-036 reset asserted mid-dump at byte 50 -> next cycle tx_valid=0, stall=1, cmd_ready=1; subsequent 'D' starts from reg0 byte0.
REQ-037 cmd_valid pulsed with 'S' during RUN -> ignored; RUN continues until prog_end.
